// File: rtl/load_station_multi.sv
// load_station_multi: DEPTH-entry load reservation station.
// Snoops NBC broadcast channels; issues the oldest ready load.
module load_station_multi #(
  parameter int DEPTH      = 4,
  parameter int DW         = 32,
  parameter int LW         = 5,
  parameter int OPW        = 5,
  parameter int NBC        = 2,
  parameter int LABEL_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              WEN,
  input  logic [OPW-1:0]    opCode,
  input  logic [OPW-1:0]    func,
  input  logic [DW-1:0]     dataIn1,
  input  logic [LW-1:0]     label1,
  input  logic [DW-1:0]     Imm,
  input  logic [NBC-1:0]    BCEN,
  input  logic [NBC*LW-1:0] BClabel,
  input  logic [NBC*DW-1:0] BCdata,
  input  logic              EXEable,
  output logic              isFull,
  output logic [LW-1:0]     allocLabel,
  output logic              OutEn,
  output logic [OPW-1:0]    opOut,
  output logic [DW-1:0]     dataOut1,
  output logic [DW-1:0]     dataOut2,
  output logic [LW-1:0]     labelOut
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_valid;
  logic [LW-1:0]    r_tag   [DEPTH];
  logic [DW-1:0]    r_data  [DEPTH];
  logic [DW-1:0]    r_imm   [DEPTH];
  logic [OPW-1:0]   r_op    [DEPTH];
  // r_older[i][j]: entry i was allocated before entry j
  logic [DEPTH-1:0] r_older [DEPTH];

  logic             r_oen;
  logic [OPW-1:0]   r_op_out;
  logic [DW-1:0]    r_d1_out;
  logic [DW-1:0]    r_d2_out;
  logic [LW-1:0]    r_lbl_out;

  logic [DEPTH-1:0] w_ready;
  logic             w_free_hit;
  logic [IW-1:0]    w_free_idx;
  logic             w_iss_hit;
  logic [IW-1:0]    w_iss_idx;
  logic             w_alloc;
  logic             w_issue;
  logic             w_byp_hit;
  logic [DW-1:0]    w_byp_data;
  logic [DEPTH-1:0] w_snp_hit;
  logic [DW-1:0]    w_snp_data [DEPTH];
  logic             w_unused_func;

  assign w_unused_func = ^func;

  assign isFull     = &r_valid;
  assign allocLabel = LW'(LABEL_BASE) + LW'(w_free_idx);
  assign w_alloc    = WEN && !isFull;
  assign w_issue    = EXEable && w_iss_hit;

  assign OutEn    = r_oen;
  assign opOut    = r_op_out;
  assign dataOut1 = r_d1_out;
  assign dataOut2 = r_d2_out;
  assign labelOut = r_lbl_out;

  // ready mask: valid entries whose operand tag has cleared
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++)
      w_ready[i] = r_valid[i] && (r_tag[i] == '0);
  end

  // lowest-index free slot
  always_comb begin
    w_free_hit = 1'b0;
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_valid[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = IW'(i);
      end
  end

  // oldest ready entry: older than every other ready entry
  always_comb begin
    w_iss_hit = 1'b0;
    w_iss_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_ready[i] &&
          ((w_ready & ~r_older[i] & ~(DEPTH'(1) << i)) == '0)) begin
        w_iss_hit = 1'b1;
        w_iss_idx = IW'(i);
      end
  end

  // write-time bypass, lowest channel wins
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = dataIn1;
    for (int c = NBC-1; c >= 0; c--)
      if (label1 != '0 && BCEN[c] &&
          BClabel[c*LW +: LW] == label1) begin
        w_byp_hit  = 1'b1;
        w_byp_data = BCdata[c*DW +: DW];
      end
  end

  // per-entry snoop, lowest channel wins
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_snp_hit[i]  = 1'b0;
      w_snp_data[i] = '0;
      for (int c = NBC-1; c >= 0; c--)
        if (r_valid[i] && r_tag[i] != '0 && BCEN[c] &&
            BClabel[c*LW +: LW] == r_tag[i]) begin
          w_snp_hit[i]  = 1'b1;
          w_snp_data[i] = BCdata[c*DW +: DW];
        end
    end
  end

  // entry storage: snoop capture, issue free, allocate
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_snp_hit[i]) begin
          r_tag[i]  <= '0;
          r_data[i] <= w_snp_data[i];
        end
      if (w_issue)
        r_valid[w_iss_idx] <= 1'b0;
      if (w_alloc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_op[w_free_idx]    <= opCode;
        r_imm[w_free_idx]   <= Imm;
        r_tag[w_free_idx]   <= w_byp_hit ? '0 : label1;
        r_data[w_free_idx]  <= w_byp_data;
        for (int j = 0; j < DEPTH; j++)
          if (IW'(j) == w_free_idx)
            r_older[j] <= '0;
          else
            r_older[j][w_free_idx] <= 1'b1;
      end
    end
  end

  // registered issue port; data holds when nothing issues
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_oen     <= 1'b0;
      r_op_out  <= '0;
      r_d1_out  <= '0;
      r_d2_out  <= '0;
      r_lbl_out <= '0;
    end else begin
      r_oen <= w_issue;
      if (w_issue) begin
        r_op_out  <= r_op[w_iss_idx];
        r_d1_out  <= r_data[w_iss_idx];
        r_d2_out  <= r_imm[w_iss_idx];
        r_lbl_out <= LW'(LABEL_BASE) + LW'(w_iss_idx);
      end
    end
  end

endmodule
